// File: rtl/traffic_pkg.sv
// traffic_pkg: phase codes, light encodings, direction constants and light decode shared by the traffic controller
package traffic_pkg;
  typedef enum logic [2:0] {
    NS_G     = 3'd0,
    NS_Y     = 3'd1,
    RED_NS   = 3'd2,
    EW_G     = 3'd3,
    EW_Y     = 3'd4,
    RED_EW   = 3'd5,
    EMG_HOLD = 3'd6
  } phase_t;
  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;
  function automatic logic [5:0] decode_lights(input phase_t p, input logic dir);
    return p == NS_G     ? {LIGHT_GRN, LIGHT_RED} :
           p == NS_Y     ? {LIGHT_YEL, LIGHT_RED} :
           p == EW_G     ? {LIGHT_RED, LIGHT_GRN} :
           p == EW_Y     ? {LIGHT_RED, LIGHT_YEL} :
           p == EMG_HOLD ? (dir == DIR_EW ? {LIGHT_RED, LIGHT_GRN} : {LIGHT_GRN, LIGHT_RED}) :
                           {LIGHT_RED, LIGHT_RED};
  endfunction
endpackage

// File: rtl/traffic_phase_controller_phase_timer.sv
// phase_timer: saturating down-counter; load beats hold beats decrement (clk, rst, load, loadVal, hold -> count, isZero)
module phase_timer #(
  parameter int BIT_WIDTH = 6,
  parameter logic [BIT_WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] loadVal,
  input  logic                 hold,
  output logic [BIT_WIDTH-1:0] count,
  output logic                 isZero
);
  logic [BIT_WIDTH-1:0] count_q;
  always_ff @(posedge clk) begin
    if (rst) count_q <= RST_VAL;
    else if (load) count_q <= loadVal;
    else if (!hold && count_q != '0) count_q <= count_q - 1'b1;
  end
  assign count = count_q;
  assign isZero = count_q == '0;
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: NS/EW phase sequencer with emergency preemption; clk/rst, carWaitNS/EW, emgReq/emgDir in; lightNS/EW, timeLeft, phase, emgActive out; GREEN_EXTEND_EN holds green at zero until the cross street has a car
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int BIT_WIDTH   = 6,
  parameter int GREEN_TIME  = 20,
  parameter int YELLOW_TIME = 4,
  parameter int RED_TIME    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 carWaitNS,
  input  logic                 carWaitEW,
  input  logic                 emgReq,
  input  logic                 emgDir,
  output logic [2:0]           lightNS,
  output logic [2:0]           lightEW,
  output logic [BIT_WIDTH-1:0] timeLeft,
  output logic [2:0]           phase,
  output logic                 emgActive
);
  localparam logic [BIT_WIDTH-1:0] G_LD = BIT_WIDTH'(GREEN_TIME - 1);
  localparam logic [BIT_WIDTH-1:0] Y_LD = BIT_WIDTH'(YELLOW_TIME - 1);
  localparam logic [BIT_WIDTH-1:0] R_LD = BIT_WIDTH'(RED_TIME - 1);
  phase_t phase_q, phase_d;
  logic emg_q, emg_d, emg_dir_q, emg_dir_d;
  logic [2:0] light_ns_q, light_ew_q;
  logic is_zero, accept, stay_ns, stay_ew;
  logic [BIT_WIDTH-1:0] load_val;
`ifdef GREEN_EXTEND_EN
  assign stay_ns = !carWaitEW;
  assign stay_ew = !carWaitNS;
`else
  logic unused_car;
  assign unused_car = carWaitNS | carWaitEW;
  assign stay_ns = 1'b0;
  assign stay_ew = 1'b0;
`endif
  assign accept = emgReq && !emg_q;
  assign emg_dir_d = accept ? emgDir : emg_dir_q;
  // an acceptance landing on an all-red zero edge is routed straight to the hold
  assign emg_d = accept | (emg_q & !(phase_q == EMG_HOLD && !emgReq));
  always_comb begin
    phase_d = phase_q == NS_G     ? (accept ? (emgDir == DIR_NS ? EMG_HOLD : NS_Y) : (is_zero && !stay_ns) ? NS_Y : NS_G) :
              phase_q == EW_G     ? (accept ? (emgDir == DIR_EW ? EMG_HOLD : EW_Y) : (is_zero && !stay_ew) ? EW_Y : EW_G) :
              phase_q == NS_Y     ? (is_zero ? RED_NS : NS_Y) :
              phase_q == EW_Y     ? (is_zero ? RED_EW : EW_Y) :
              phase_q == RED_NS   ? (is_zero ? ((emg_q || accept) ? EMG_HOLD : EW_G) : RED_NS) :
              phase_q == RED_EW   ? (is_zero ? ((emg_q || accept) ? EMG_HOLD : NS_G) : RED_EW) :
              phase_q == EMG_HOLD ? (emgReq ? EMG_HOLD : (emg_dir_q == DIR_EW ? EW_Y : NS_Y)) :
                                    RED_EW;
    load_val = (phase_d == NS_G || phase_d == EW_G) ? G_LD :
               (phase_d == NS_Y || phase_d == EW_Y) ? Y_LD :
               phase_d == EMG_HOLD ? '0 : R_LD;
  end
  phase_timer #(.BIT_WIDTH(BIT_WIDTH), .RST_VAL(R_LD)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(phase_d != phase_q),
    .loadVal(load_val),
    .hold(phase_q == EMG_HOLD),
    .count(timeLeft),
    .isZero(is_zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= RED_EW;
      emg_q <= 1'b0;
      emg_dir_q <= DIR_NS;
      {light_ns_q, light_ew_q} <= {LIGHT_RED, LIGHT_RED};
    end else begin
      phase_q <= phase_d;
      emg_q <= emg_d;
      emg_dir_q <= emg_dir_d;
      {light_ns_q, light_ew_q} <= decode_lights(phase_d, emg_dir_d);
    end
  end
  assign phase = phase_q;
  assign emgActive = emg_q;
  assign lightNS = light_ns_q;
  assign lightEW = light_ew_q;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: directed checks of sequencing, preemption, reset and green length
module tb_traffic_phase_controller;
  logic clk = 1'b0, rst = 1'b1, carWaitNS = 1'b0, carWaitEW = 1'b0, emgReq = 1'b0, emgDir = 1'b0;
  logic [2:0] lightNS, lightEW, phase;
  logic [5:0] timeLeft;
  logic emgActive;
  int checks = 0, passed = 0;
  logic [15:0] obs, exp_v;
  traffic_phase_controller dut (
    .clk(clk), .rst(rst), .carWaitNS(carWaitNS), .carWaitEW(carWaitEW),
    .emgReq(emgReq), .emgDir(emgDir), .lightNS(lightNS), .lightEW(lightEW),
    .timeLeft(timeLeft), .phase(phase), .emgActive(emgActive)
  );
  always #5 clk = ~clk;
  assign obs = {phase, timeLeft, lightNS, lightEW, emgActive};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs !== {3'd5, 6'd1, 3'b100, 3'b100, 1'b0}) $display("FAIL reset_state got %h want %h", obs, {3'd5, 6'd1, 3'b100, 3'b100, 1'b0}); else passed++;
    tick();
    checks++;
    if (obs !== {3'd5, 6'd0, 3'b100, 3'b100, 1'b0}) $display("FAIL reset_red_zero got %h want %h", obs, {3'd5, 6'd0, 3'b100, 3'b100, 1'b0}); else passed++;
    tick();
    checks++;
    if (obs !== {3'd0, 6'd19, 3'b001, 3'b100, 1'b0}) $display("FAIL first_ns_green got %h want %h", obs, {3'd0, 6'd19, 3'b001, 3'b100, 1'b0}); else passed++;
  endtask
  task automatic test_full_cycle();
    for (int k = 0; k < 52; k++) begin
      exp_v = k < 20 ? {3'd0, 6'(19 - k), 3'b001, 3'b100, 1'b0} :
              k < 24 ? {3'd1, 6'(23 - k), 3'b010, 3'b100, 1'b0} :
              k < 26 ? {3'd2, 6'(25 - k), 3'b100, 3'b100, 1'b0} :
              k < 46 ? {3'd3, 6'(45 - k), 3'b100, 3'b001, 1'b0} :
              k < 50 ? {3'd4, 6'(49 - k), 3'b100, 3'b010, 1'b0} :
                       {3'd5, 6'(51 - k), 3'b100, 3'b100, 1'b0};
      checks++;
      if (obs !== exp_v) $display("FAIL cycle_step_%0d got %h want %h", k, obs, exp_v); else passed++;
      tick();
    end
    checks++;
    if (obs !== {3'd0, 6'd19, 3'b001, 3'b100, 1'b0}) $display("FAIL cycle_wrap got %h want %h", obs, {3'd0, 6'd19, 3'b001, 3'b100, 1'b0}); else passed++;
  endtask
  task automatic test_emg_opposite();
    repeat (5) tick();
    emgReq = 1'b1;
    emgDir = 1'b1;
    tick();
    checks++;
    if (obs !== {3'd1, 6'd3, 3'b010, 3'b100, 1'b1}) $display("FAIL emg_truncate got %h want %h", obs, {3'd1, 6'd3, 3'b010, 3'b100, 1'b1}); else passed++;
    repeat (3) tick();
    checks++;
    if (obs !== {3'd1, 6'd0, 3'b010, 3'b100, 1'b1}) $display("FAIL emg_yellow_end got %h want %h", obs, {3'd1, 6'd0, 3'b010, 3'b100, 1'b1}); else passed++;
    repeat (3) tick();
    checks++;
    if (obs !== {3'd6, 6'd0, 3'b100, 3'b001, 1'b1}) $display("FAIL emg_hold_ew got %h want %h", obs, {3'd6, 6'd0, 3'b100, 3'b001, 1'b1}); else passed++;
    emgDir = 1'b0;
    tick();
    checks++;
    if (obs !== {3'd6, 6'd0, 3'b100, 3'b001, 1'b1}) $display("FAIL emg_hold_dir_ignored got %h want %h", obs, {3'd6, 6'd0, 3'b100, 3'b001, 1'b1}); else passed++;
    emgReq = 1'b0;
    tick();
    checks++;
    if (obs !== {3'd4, 6'd3, 3'b100, 3'b010, 1'b0}) $display("FAIL emg_release got %h want %h", obs, {3'd4, 6'd3, 3'b100, 3'b010, 1'b0}); else passed++;
    repeat (4) tick();
    checks++;
    if (obs !== {3'd5, 6'd1, 3'b100, 3'b100, 1'b0}) $display("FAIL emg_resume_red got %h want %h", obs, {3'd5, 6'd1, 3'b100, 3'b100, 1'b0}); else passed++;
    repeat (2) tick();
    checks++;
    if (obs !== {3'd0, 6'd19, 3'b001, 3'b100, 1'b0}) $display("FAIL emg_resume_green got %h want %h", obs, {3'd0, 6'd19, 3'b001, 3'b100, 1'b0}); else passed++;
  endtask
  task automatic test_emg_same();
    repeat (2) tick();
    emgReq = 1'b1;
    emgDir = 1'b0;
    tick();
    checks++;
    if (obs !== {3'd6, 6'd0, 3'b001, 3'b100, 1'b1}) $display("FAIL emg_same_hold got %h want %h", obs, {3'd6, 6'd0, 3'b001, 3'b100, 1'b1}); else passed++;
    emgReq = 1'b0;
    tick();
    checks++;
    if (obs !== {3'd1, 6'd3, 3'b010, 3'b100, 1'b0}) $display("FAIL emg_pulse_exit got %h want %h", obs, {3'd1, 6'd3, 3'b010, 3'b100, 1'b0}); else passed++;
  endtask
  task automatic test_reset_mid();
    emgReq = 1'b1;
    emgDir = 1'b1;
    tick();
    checks++;
    if (obs !== {3'd1, 6'd2, 3'b010, 3'b100, 1'b1}) $display("FAIL emg_in_yellow got %h want %h", obs, {3'd1, 6'd2, 3'b010, 3'b100, 1'b1}); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    emgReq = 1'b0;
    checks++;
    if (obs !== {3'd5, 6'd1, 3'b100, 3'b100, 1'b0}) $display("FAIL reset_mid got %h want %h", obs, {3'd5, 6'd1, 3'b100, 3'b100, 1'b0}); else passed++;
    tick();
    checks++;
    if (obs !== {3'd5, 6'd0, 3'b100, 3'b100, 1'b0}) $display("FAIL reset_mid_count got %h want %h", obs, {3'd5, 6'd0, 3'b100, 3'b100, 1'b0}); else passed++;
  endtask
  task automatic test_green_length();
    carWaitEW = 1'b0;
    carWaitNS = 1'b0;
    tick();
    repeat (19) tick();
    checks++;
    if (obs !== {3'd0, 6'd0, 3'b001, 3'b100, 1'b0}) $display("FAIL green_zero got %h want %h", obs, {3'd0, 6'd0, 3'b001, 3'b100, 1'b0}); else passed++;
`ifdef GREEN_EXTEND_EN
    repeat (30) tick();
    checks++;
    if (obs !== {3'd0, 6'd0, 3'b001, 3'b100, 1'b0}) $display("FAIL green_extended got %h want %h", obs, {3'd0, 6'd0, 3'b001, 3'b100, 1'b0}); else passed++;
    carWaitEW = 1'b1;
`endif
    tick();
    checks++;
    if (obs !== {3'd1, 6'd3, 3'b010, 3'b100, 1'b0}) $display("FAIL green_end got %h want %h", obs, {3'd1, 6'd3, 3'b010, 3'b100, 1'b0}); else passed++;
  endtask
  initial begin
    test_reset();
    test_full_cycle();
    test_emg_opposite();
    test_emg_same();
    test_reset_mid();
    test_green_length();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
